// File: rtl/hd44780_ctrl_if.sv
// Pin and handshake bundle between the HD44780 controller and its neighbours.
// Combinational wiring only; no latency of its own.
// cmd_valid/cmd_ready is the only flow-controlled path; trg is a fire-and-forget pulse.
interface hd44780_ctrl_if #(
  parameter int BUS_WIDTH = 4,
  parameter int AW        = 6
);
  logic                 trg;
  logic                 cmd_valid;
  logic [7:0]           cmd_data;
  logic                 cmd_ready;
  logic                 busy;
  logic                 e;
  logic                 rs;
  logic [BUS_WIDTH-1:0] db;
  logic [AW-1:0]        idataaddr;
  logic [7:0]           idata;

  // Controller side.
  modport master (
    input  trg, cmd_valid, cmd_data, idata,
    output cmd_ready, busy, e, rs, db, idataaddr
  );

  // Host / LCD / character-memory side.
  modport slave (
    output trg, cmd_valid, cmd_data, idata,
    input  cmd_ready, busy, e, rs, db, idataaddr
  );
endinterface

// File: rtl/hd44780_ctrl.sv
// HD44780 character-LCD controller: power-on init, full-screen refresh from char RAM, raw commands.
// Latency: each byte costs setup+E_PULSE+hold (twice plus NIBBLE_GAP in 4-bit mode) plus its post-delay.
// Backpressure: cmd_ready only in IDLE; trg never stalls, it collapses into a single pending refresh.
module hd44780_ctrl #(
  parameter int unsigned CLK_FREQ_HZ  = 250000,
  parameter int unsigned BUS_WIDTH    = 4,
  parameter int unsigned LINES        = 4,
  parameter int unsigned COLS         = 16,
  parameter int unsigned POWERON_US   = 100000,
  parameter int unsigned CLEAR_US     = 10000,
  parameter int unsigned CMD_US       = 80,
  parameter int unsigned NIBBLE_GAP   = 10,
  parameter int unsigned E_PULSE      = 1,
  parameter int unsigned CURSOR_ON    = 1,
  parameter int unsigned CURSOR_BLINK = 0
) (
  input logic           clk,
  input logic           rst,
  hd44780_ctrl_if.master bus
);

  // Microseconds to clock cycles, rounded up, never zero; 64-bit to survive large products.
  function automatic int unsigned us2cyc(input longint unsigned us);
    longint unsigned c;
    c = (us * 64'(CLK_FREQ_HZ) + 64'd999999) / 64'd1000000;
    if (c == 64'd0) c = 64'd1;
    return c[31:0];
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned C_PWR  = us2cyc(POWERON_US);
  localparam int unsigned C_CLR  = us2cyc(CLEAR_US);
  localparam int unsigned C_CMD  = us2cyc(CMD_US);
  localparam int unsigned C_4100 = us2cyc(4100);
  localparam int unsigned C_100  = us2cyc(100);
  localparam int unsigned EP     = (E_PULSE == 0) ? 1 : E_PULSE;
  localparam int unsigned C_MAX  = max2(max2(max2(C_PWR, C_CLR), max2(C_4100, C_100)),
                                        max2(max2(C_CMD, NIBBLE_GAP), max2(EP, 2)));
  localparam int CW = $clog2(C_MAX + 1);
  localparam int AW = (LINES * COLS > 1) ? $clog2(LINES * COLS) : 1;
  localparam bit BUS8 = (BUS_WIDTH == 8);

  localparam logic [7:0] FUNC_SET = 8'h20 | (BUS8 ? 8'h10 : 8'h00) | ((LINES > 1) ? 8'h08 : 8'h00);
  localparam logic [7:0] DISP_CTL = 8'h0C | ((CURSOR_ON != 0) ? 8'h02 : 8'h00)
                                          | ((CURSOR_BLINK != 0) ? 8'h01 : 8'h00);

  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, REFRESH, CMD} state_t;
  typedef enum logic [2:0] {PH_WAIT, PH_FETCH, PH_SETUP, PH_PULSE, PH_HOLD, PH_GAP, PH_DELAY} phase_t;

  // DDRAM start address of each display line.
  function automatic logic [7:0] line_base(input logic [1:0] l);
    case (l)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'(COLS);
      default: return 8'(8'h40 + COLS);
    endcase
  endfunction

  state_t               state_q, state_d;
  phase_t               ph_q, ph_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        dly_q, dly_d;
  logic [2:0]           step_q, step_d;
  logic [1:0]           line_q, line_d;
  logic [5:0]           col_q, col_d;
  logic                 instr_q, instr_d;
  logic                 pend_q, pend_d;
  logic [7:0]           byte_q, byte_d;
  logic                 single_q, single_d;
  logic                 hi_q, hi_d;
  logic                 e_q, e_d;
  logic                 rs_q, rs_d;
  logic [BUS_WIDTH-1:0] db_q, db_d;
  logic [AW-1:0]        addr_q, addr_d;

  logic       next_op, finish, start_refresh, init_go, low_setup;
  logic       go, go_fetch, go_rs, go_single;
  logic [7:0] go_byte;
  logic [CW-1:0] go_dly;

  // Sequencer: top-level state picks the next byte, the phase machine drives one bus write.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;
    dly_d    = dly_q;
    step_d   = step_q;
    line_d   = line_q;
    col_d    = col_q;
    instr_d  = instr_q;
    pend_d   = pend_q | bus.trg;
    byte_d   = byte_q;
    single_d = single_q;
    hi_d     = hi_q;
    e_d      = e_q;
    rs_d     = rs_q;
    db_d     = db_q;
    addr_d   = addr_q;
    next_op       = 1'b0;
    finish        = 1'b0;
    start_refresh = 1'b0;
    init_go       = 1'b0;
    low_setup     = 1'b0;
    go        = 1'b0;
    go_fetch  = 1'b0;
    go_rs     = 1'b0;
    go_single = 1'b0;
    go_byte   = 8'h00;
    go_dly    = CW'(C_CMD);

    case (ph_q)
      PH_WAIT: begin
        if (state_q == PWR_WAIT) begin
          if (cnt_q == CW'(1)) begin
            state_d = INIT;
            step_d  = 3'd0;
            init_go = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end else if (state_q == IDLE) begin
          if (bus.cmd_valid) begin
            state_d = CMD;
            go      = 1'b1;
            go_byte = bus.cmd_data;
          end else if (pend_q || bus.trg) begin
            start_refresh = 1'b1;
          end
        end
      end
      PH_FETCH: begin
        // Address went out two edges ago; the synchronous RAM answer is on idata now.
        if (cnt_q == CW'(1)) begin
          go      = 1'b1;
          go_rs   = 1'b1;
          go_byte = bus.idata;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PH_SETUP: begin
        e_d   = 1'b1;
        cnt_d = CW'(EP);
        ph_d  = PH_PULSE;
      end
      PH_PULSE: begin
        if (cnt_q == CW'(1)) begin
          e_d  = 1'b0;
          ph_d = PH_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PH_HOLD: begin
        if (!BUS8 && hi_q && !single_q) begin
          if (NIBBLE_GAP == 0) begin
            low_setup = 1'b1;
          end else begin
            ph_d  = PH_GAP;
            cnt_d = CW'(NIBBLE_GAP);
          end
        end else begin
          ph_d  = PH_DELAY;
          cnt_d = dly_q;
        end
      end
      PH_GAP: begin
        if (cnt_q == CW'(1)) low_setup = 1'b1;
        else                 cnt_d = cnt_q - CW'(1);
      end
      PH_DELAY: begin
        if (cnt_q == CW'(1)) next_op = 1'b1;
        else                 cnt_d = cnt_q - CW'(1);
      end
      default: ph_d = PH_WAIT;
    endcase

    if (low_setup) begin
      ph_d = PH_SETUP;
      hi_d = 1'b0;
      db_d = BUS_WIDTH'(byte_q[3:0]);
    end

    if (next_op) begin
      case (state_q)
        INIT: begin
          if (step_q == 3'd7) begin
            finish = 1'b1;
          end else begin
            // 8-bit mode has no switch-to-4-bit nibble.
            step_d  = (BUS8 && step_q == 3'd2) ? 3'd4 : step_q + 3'd1;
            init_go = 1'b1;
          end
        end
        REFRESH: begin
          if (instr_q) begin
            instr_d  = 1'b0;
            col_d    = 6'd0;
            go       = 1'b1;
            go_fetch = 1'b1;
          end else if (col_q != 6'(COLS - 1)) begin
            col_d    = col_q + 6'd1;
            go       = 1'b1;
            go_fetch = 1'b1;
          end else if (line_q != 2'(LINES - 1)) begin
            line_d  = line_q + 2'd1;
            instr_d = 1'b1;
            go      = 1'b1;
            go_byte = 8'h80 | line_base(line_q + 2'd1);
          end else begin
            finish = 1'b1;
          end
        end
        default: finish = 1'b1;
      endcase
    end

    // A refresh requested while busy chains straight on, so busy never dips in between.
    if (finish) begin
      if (pend_q || bus.trg) begin
        start_refresh = 1'b1;
      end else begin
        state_d = IDLE;
        ph_d    = PH_WAIT;
        rs_d    = 1'b0;
        db_d    = '0;
      end
    end

    if (start_refresh) begin
      state_d = REFRESH;
      pend_d  = 1'b0;
      line_d  = 2'd0;
      col_d   = 6'd0;
      instr_d = 1'b1;
      go      = 1'b1;
      go_byte = 8'h80 | line_base(2'd0);
    end

    if (init_go) begin
      go = 1'b1;
      case (step_d)
        3'd0, 3'd1, 3'd2: begin go_byte = 8'h30; go_single = 1'b1; end
        3'd3:             begin go_byte = 8'h20; go_single = 1'b1; end
        3'd4:             go_byte = FUNC_SET;
        3'd5:             go_byte = DISP_CTL;
        3'd6:             go_byte = 8'h01;
        default:          go_byte = 8'h06;
      endcase
    end

    // Clear/home get the long wait; data bytes that happen to be 0x01/0x02 do not.
    if (init_go && step_d == 3'd0)      go_dly = CW'(C_4100);
    else if (init_go && step_d == 3'd1) go_dly = CW'(C_100);
    else if (!go_rs && !go_single && (go_byte == 8'h01 || go_byte == 8'h02)) go_dly = CW'(C_CLR);
    else                                go_dly = CW'(C_CMD);

    if (go) begin
      if (go_fetch) begin
        ph_d   = PH_FETCH;
        cnt_d  = CW'(2);
        addr_d = AW'(32'(line_d) * COLS + 32'(col_d));
      end else begin
        ph_d     = PH_SETUP;
        byte_d   = go_byte;
        single_d = go_single;
        hi_d     = 1'b1;
        dly_d    = go_dly;
        rs_d     = go_rs;
        e_d      = 1'b0;
        db_d     = BUS8 ? BUS_WIDTH'(go_byte) : BUS_WIDTH'(go_byte[7:4]);
      end
    end
  end

  // State and output registers; reset restarts the whole power-on sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= PWR_WAIT;
      ph_q     <= PH_WAIT;
      cnt_q    <= CW'(C_PWR);
      dly_q    <= '0;
      step_q   <= 3'd0;
      line_q   <= 2'd0;
      col_q    <= 6'd0;
      instr_q  <= 1'b0;
      pend_q   <= 1'b0;
      byte_q   <= 8'h00;
      single_q <= 1'b0;
      hi_q     <= 1'b0;
      e_q      <= 1'b0;
      rs_q     <= 1'b0;
      db_q     <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      cnt_q    <= cnt_d;
      dly_q    <= dly_d;
      step_q   <= step_d;
      line_q   <= line_d;
      col_q    <= col_d;
      instr_q  <= instr_d;
      pend_q   <= pend_d;
      byte_q   <= byte_d;
      single_q <= single_d;
      hi_q     <= hi_d;
      e_q      <= e_d;
      rs_q     <= rs_d;
      db_q     <= db_d;
      addr_q   <= addr_d;
    end
  end

  assign bus.e         = e_q;
  assign bus.rs        = rs_q;
  assign bus.db        = db_q;
  assign bus.idataaddr = addr_q;
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE) || pend_q;

endmodule

// File: tb/tb_hd44780_ctrl.sv
// Scoreboard bench: a 4-bit 4x20 controller and an 8-bit 2x16 controller share clock and reset.
// Stimulus pushes expected bus writes; monitors pop one entry per rising edge of e.
// Timing points (first e rise, post-delays, busy fall) are checked against hand-derived counts.
module tb_hd44780_ctrl;

  typedef struct packed {
    logic       rs;
    logic [7:0] byt;
    logic [7:0] bus;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hd44780_ctrl_if #(.BUS_WIDTH(4), .AW(7)) b4 ();
  hd44780_ctrl_if #(.BUS_WIDTH(8), .AW(5)) b8 ();

  hd44780_ctrl #(.BUS_WIDTH(4), .LINES(4), .COLS(20)) dut4 (.clk(clk), .rst(rst), .bus(b4.master));
  hd44780_ctrl #(.BUS_WIDTH(8), .LINES(2), .COLS(16), .CURSOR_ON(0)) dut8 (.clk(clk), .rst(rst), .bus(b8.master));

  // Character memory holding its own address; one-cycle synchronous read.
  always @(posedge clk) b4.idata <= {1'b0, b4.idataaddr};

  exp_t q4[$];
  exp_t q8[$];
  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int first_rise = -1;
  int last_rise  = 0;
  int addr_chg   = 0;
  int rdy_viol   = 0;
  bit watch_rdy  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic push4_byte(input logic rs_v, input logic [7:0] b);
    exp_t x;
    x.rs = rs_v; x.byt = b; x.bus = {4'h0, b[7:4]}; q4.push_back(x);
    x.bus = {4'h0, b[3:0]}; q4.push_back(x);
  endtask

  task automatic push4_nib(input logic [3:0] n);
    exp_t x;
    x.rs = 1'b0; x.byt = {n, 4'h0}; x.bus = {4'h0, n}; q4.push_back(x);
  endtask

  // 3,3,3,2 then function set 0x28, display 0x0E (cursor on), clear, entry mode.
  task automatic push4_init();
    push4_nib(4'h3); push4_nib(4'h3); push4_nib(4'h3); push4_nib(4'h2);
    push4_byte(1'b0, 8'h28); push4_byte(1'b0, 8'h0E);
    push4_byte(1'b0, 8'h01); push4_byte(1'b0, 8'h06);
  endtask

  task automatic push8_init();
    logic [7:0] seq [7];
    exp_t x;
    seq = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < 7; i++) begin
      x.rs = 1'b0; x.byt = seq[i]; x.bus = seq[i]; q8.push_back(x);
    end
  endtask

  task automatic push4_refresh();
    logic [7:0] cmds [4];
    cmds = '{8'h80, 8'hC0, 8'h94, 8'hD4};
    for (int l = 0; l < 4; l++) begin
      push4_byte(1'b0, cmds[l]);
      for (int c = 0; c < 20; c++) push4_byte(1'b1, 8'(l * 20 + c));
    end
  endtask

  // Monitor for the 4-bit controller.
  logic       pe4 = 1'b0;
  logic [6:0] paddr = '0;
  always @(negedge clk) begin
    exp_t x;
    if (!rst) begin
      pe4   = 1'b0;
      paddr = b4.idataaddr;
    end else begin
      if (b4.idataaddr != paddr) begin
        addr_chg = cyc;
        paddr    = b4.idataaddr;
      end
      if (watch_rdy && b4.cmd_ready) rdy_viol++;
      if (b4.e && !pe4) begin
        if (first_rise < 0) first_rise = cyc;
        last_rise = cyc;
        if (q4.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_xfer4: got rs=%0d db=%0h, required no transfer", b4.rs, b4.db);
        end else begin
          x = q4.pop_front();
          chk("xfer4_rs", b4.rs, x.rs);
          chk("xfer4_db", b4.db, x.bus[3:0]);
          if (x.rs) begin
            chk("xfer4_idataaddr", b4.idataaddr, x.byt);
            chk("addr_before_setup", (cyc - addr_chg >= 2) ? 1 : 0, 1);
          end
        end
      end
      pe4 = b4.e;
    end
  end

  // Monitor for the 8-bit controller.
  logic pe8 = 1'b0;
  always @(negedge clk) begin
    exp_t x;
    if (!rst) begin
      pe8 = 1'b0;
    end else begin
      if (b8.e && !pe8) begin
        if (q8.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_xfer8: got rs=%0d db=%0h, required no transfer", b8.rs, b8.db);
        end else begin
          x = q8.pop_front();
          chk("xfer8_rs", b8.rs, x.rs);
          chk("xfer8_db", b8.db, x.bus);
        end
      end
      pe8 = b8.e;
    end
  end

  task automatic wait_idle(input string nm, input bit sel8, input int budget);
    int n;
    n = 0;
    while ((sel8 ? b8.busy : b4.busy) !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if ((sel8 ? b8.busy : b4.busy) !== 1'b0) begin
      compared++; mismatched++;
      $display("FAIL %s: busy still high after %0d cycles, required low", nm, budget);
    end
  endtask

  task automatic wait_q4(input string nm, input int left, input int budget);
    int n;
    n = 0;
    while (q4.size() > left && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q4.size() > left) begin
      compared++; mismatched++;
      $display("FAIL %s: %0d entries outstanding, required %0d", nm, q4.size(), left);
    end
  endtask

  task automatic pulse_trg();
    b4.trg = 1'b1;
    @(negedge clk);
    b4.trg = 1'b0;
  endtask

  task automatic run_init(input string nm);
    int rel;
    first_rise = -1;
    rel = cyc;
    rst = 1'b1;
    wait_idle({nm, "_4"}, 1'b0, 30000);
    chk({nm, "_first_e_rise"}, first_rise - rel, 25001);
    chk({nm, "_tail_to_idle"}, cyc - last_rise, 22);
    chk({nm, "_q4_left"}, q4.size(), 0);
    wait_idle({nm, "_8"}, 1'b1, 5000);
    chk({nm, "_q8_left"}, q8.size(), 0);
  endtask

  initial begin
    int t_clr;
    int n;
    b4.trg = 1'b0; b4.cmd_valid = 1'b0; b4.cmd_data = 8'h00;
    b8.trg = 1'b0; b8.cmd_valid = 1'b0; b8.cmd_data = 8'h00; b8.idata = 8'h00;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_e", b4.e, 0);
    chk("rst_rs", b4.rs, 0);
    chk("rst_db", b4.db, 0);
    chk("rst_busy", b4.busy, 1);
    chk("rst_cmd_ready", b4.cmd_ready, 0);
    chk("rst_idataaddr", b4.idataaddr, 0);
    chk("rst8_busy", b8.busy, 1);
    chk("rst8_db", b8.db, 0);

    push4_init();
    push8_init();
    run_init("init");
    chk("idle_cmd_ready", b4.cmd_ready, 1);

    // Single refresh from IDLE.
    push4_refresh();
    pulse_trg();
    chk("refresh_busy", b4.busy, 1);
    wait_idle("refresh1", 1'b0, 6000);
    chk("refresh1_left", q4.size(), 0);
    chk("refresh1_rs_after", b4.rs, 0);
    chk("refresh1_db_after", b4.db, 0);

    // Two pulses mid-refresh collapse into one extra refresh with no busy gap.
    push4_refresh();
    push4_refresh();
    pulse_trg();
    repeat (300) @(negedge clk);
    pulse_trg();
    repeat (100) @(negedge clk);
    pulse_trg();
    wait_idle("refresh2", 1'b0, 12000);
    chk("refresh2_left_at_busy_fall", q4.size(), 0);
    repeat (400) @(negedge clk);
    chk("refresh2_no_third", b4.busy, 0);

    // Command and trigger in the same cycle: clear first, then refresh.
    push4_byte(1'b0, 8'h01);
    push4_refresh();
    b4.cmd_valid = 1'b1; b4.cmd_data = 8'h01; b4.trg = 1'b1;
    chk("cmd_handshake_ready", b4.cmd_ready, 1);
    @(negedge clk);
    b4.cmd_valid = 1'b0; b4.cmd_data = 8'h00; b4.trg = 1'b0;
    rdy_viol  = 0;
    watch_rdy = 1'b1;
    wait_q4("cmd_clear", 168, 200);
    t_clr = last_rise;
    wait_q4("cmd_first_refresh", 167, 4000);
    chk("clear_wait", last_rise - t_clr, 2503);
    wait_idle("cmd_refresh", 1'b0, 6000);
    watch_rdy = 1'b0;
    chk("cmd_ready_low_throughout", rdy_viol, 0);
    chk("cmd_refresh_left", q4.size(), 0);

    // Reset during character 7 with a refresh pending.
    push4_refresh();
    pulse_trg();
    repeat (50) @(negedge clk);
    pulse_trg();
    n = 0;
    while (!(b4.idataaddr == 7'd7 && b4.e) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_char7", (b4.idataaddr == 7'd7 && b4.e) ? 1 : 0, 1);
    rst = 1'b0;
    #1;
    chk("abort_e", b4.e, 0);
    chk("abort_rs", b4.rs, 0);
    chk("abort_db", b4.db, 0);
    chk("abort_idataaddr", b4.idataaddr, 0);
    chk("abort_busy", b4.busy, 1);
    chk("abort_cmd_ready", b4.cmd_ready, 0);
    q4.delete();
    q8.delete();
    push4_init();
    push8_init();
    repeat (2) @(negedge clk);
    run_init("reinit");
    repeat (500) @(negedge clk);
    chk("no_pending_after_reset", b4.busy, 0);
    chk("no_refresh_after_reset", q4.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
